// File: rtl/q_updater.sv
`timescale 1ns/1ps
// q_updater: pipelined Q-learning update feeding the memory interface stage.
// Q_new = Q_old + 2^-alpha_sh * (R + (1 - 2^-gamma_sh) * max(D_next) - Q_old),
// saturated to Q_WIDTH. Four compute stages plus a registered output stage.
// Every stage advances together unless the output is stalled.
module q_updater #(
    parameter int Q_WIDTH  = 16,
    parameter int R_WIDTH  = 16,
    parameter int SH_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4*Q_WIDTH-1:0]        D_next,
    input  logic signed [Q_WIDTH-1:0]   Q_old,
    input  logic signed [R_WIDTH-1:0]   R,
    input  logic [SH_WIDTH-1:0]         alpha_sh,
    input  logic [SH_WIDTH-1:0]         gamma_sh,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [Q_WIDTH-1:0]   Q_new,
    output logic signed [Q_WIDTH-1:0]   q_max,
    output logic [1:0]                  best_road,
    output logic                        sat_flag,
    output logic [31:0]                 upd_cnt
);

    // Two guard bits cover R + gq and the later subtraction of Q_old.
    localparam int TW = Q_WIDTH + 2;
    localparam logic signed [Q_WIDTH-1:0] QN_HI = {1'b0, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [Q_WIDTH-1:0] QN_LO = {1'b1, {(Q_WIDTH-1){1'b0}}};
    localparam logic signed [TW-1:0]      SAT_HI = TW'(QN_HI);
    localparam logic signed [TW-1:0]      SAT_LO = TW'(QN_LO);

    logic stall, advance, accept, rdy_en;

    // Ready is held off until the first edge after reset release.
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = rdy_en && !stall;
    assign accept   = in_valid && in_ready;

    // Pair compares on the incoming beat; ties keep the lower road.
    logic signed [Q_WIDTH-1:0] d0, d1, d2, d3;
    logic                      p01_hi, p23_hi;
    assign d0 = D_next[0*Q_WIDTH +: Q_WIDTH];
    assign d1 = D_next[1*Q_WIDTH +: Q_WIDTH];
    assign d2 = D_next[2*Q_WIDTH +: Q_WIDTH];
    assign d3 = D_next[3*Q_WIDTH +: Q_WIDTH];
    assign p01_hi = d1 > d0;
    assign p23_hi = d3 > d2;

    logic                      v1, v2, v3, v4;
    logic signed [Q_WIDTH-1:0] s1_a, s1_b, s1_qo;
    logic                      s1_ai, s1_bi;
    logic signed [R_WIDTH-1:0] s1_r;
    logic [SH_WIDTH-1:0]       s1_alpha, s1_gamma;

    logic signed [Q_WIDTH-1:0] s2_qmax, s2_qo;
    logic [1:0]                s2_best;
    logic signed [R_WIDTH-1:0] s2_r;
    logic [SH_WIDTH-1:0]       s2_alpha, s2_gamma;

    logic signed [TW-1:0]      s3_target;
    logic signed [Q_WIDTH-1:0] s3_qmax, s3_qo;
    logic [1:0]                s3_best;
    logic [SH_WIDTH-1:0]       s3_alpha;

    logic signed [TW-1:0]      s4_sum;
    logic signed [Q_WIDTH-1:0] s4_qmax;
    logic [1:0]                s4_best;

    // Final compare between pair winners; the lower pair wins a tie.
    logic                      b_hi;
    logic signed [Q_WIDTH-1:0] qmax_c;
    logic [1:0]                best_c;
    assign b_hi   = s1_b > s1_a;
    assign qmax_c = b_hi ? s1_b : s1_a;
    assign best_c = b_hi ? {1'b1, s1_bi} : {1'b0, s1_ai};

    // Discounted max: gamma_sh = 0 cancels to zero.
    logic signed [TW-1:0] qmax_x, gq, target_c;
    assign qmax_x   = TW'(s2_qmax);
    assign gq       = qmax_x - (qmax_x >>> s2_gamma);
    assign target_c = TW'(s2_r) + gq;

    // Arithmetic shift floors the scaled error toward -inf.
    logic signed [TW-1:0] qo_x, err, delta, sum_c;
    assign qo_x  = TW'(s3_qo);
    assign err   = s3_target - qo_x;
    assign delta = err >>> s3_alpha;
    assign sum_c = qo_x + delta;

    logic                      clip_hi, clip_lo;
    logic signed [Q_WIDTH-1:0] qn_c;
    assign clip_hi = s4_sum > SAT_HI;
    assign clip_lo = s4_sum < SAT_LO;
    assign qn_c    = clip_hi ? QN_HI : (clip_lo ? QN_LO : s4_sum[Q_WIDTH-1:0]);

    // Input readiness enable after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_en <= 1'b0;
        else      rdy_en <= 1'b1;
    end

    // Stage registers S1..S4; the whole pipe freezes on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {v1, v2, v3, v4} <= '0;
            s1_a <= '0; s1_b <= '0; s1_ai <= 1'b0; s1_bi <= 1'b0;
            s1_r <= '0; s1_qo <= '0; s1_alpha <= '0; s1_gamma <= '0;
            s2_qmax <= '0; s2_best <= '0; s2_r <= '0; s2_qo <= '0;
            s2_alpha <= '0; s2_gamma <= '0;
            s3_target <= '0; s3_qmax <= '0; s3_best <= '0; s3_qo <= '0; s3_alpha <= '0;
            s4_sum <= '0; s4_qmax <= '0; s4_best <= '0;
        end else if (advance) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
            s1_a     <= p01_hi ? d1 : d0;
            s1_ai    <= p01_hi;
            s1_b     <= p23_hi ? d3 : d2;
            s1_bi    <= p23_hi;
            s1_r     <= R;
            s1_qo    <= Q_old;
            s1_alpha <= alpha_sh;
            s1_gamma <= gamma_sh;
            s2_qmax  <= qmax_c;
            s2_best  <= best_c;
            s2_r     <= s1_r;
            s2_qo    <= s1_qo;
            s2_alpha <= s1_alpha;
            s2_gamma <= s1_gamma;
            s3_target <= target_c;
            s3_qmax   <= s2_qmax;
            s3_best   <= s2_best;
            s3_qo     <= s2_qo;
            s3_alpha  <= s2_alpha;
            s4_sum    <= sum_c;
            s4_qmax   <= s3_qmax;
            s4_best   <= s3_best;
        end
    end

    // Registered outputs, sticky saturation flag and accepted-result counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            Q_new     <= '0;
            q_max     <= '0;
            best_road <= '0;
            sat_flag  <= 1'b0;
            upd_cnt   <= '0;
        end else begin
            if (advance) begin
                out_valid <= v4;
                if (v4) begin
                    Q_new     <= qn_c;
                    q_max     <= s4_qmax;
                    best_road <= s4_best;
                    if (clip_hi || clip_lo) sat_flag <= 1'b1;
                end
            end
            if (out_valid && out_ready) upd_cnt <= upd_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_q_updater.sv
`timescale 1ns/1ps
// Testbench for q_updater: directed cases plus a random soak, with a
// scoreboard fed on every accepted beat and drained on every emitted result.
module tb_q_updater;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic [63:0]        D_next;
    logic signed [15:0] Q_old, R;
    logic [3:0]         alpha_sh, gamma_sh;
    logic               out_valid, out_ready;
    logic signed [15:0] Q_new, q_max;
    logic [1:0]         best_road;
    logic               sat_flag;
    logic [31:0]        upd_cnt;

    typedef struct {
        logic signed [15:0] qn;
        logic signed [15:0] qm;
        logic [1:0]         br;
    } exp_t;

    exp_t               sb[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 n_acc   = 0;
    logic               prev_stall = 1'b0;
    logic signed [15:0] prev_qn, prev_qm;

    q_updater dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .D_next(D_next), .Q_old(Q_old), .R(R),
        .alpha_sh(alpha_sh), .gamma_sh(gamma_sh),
        .out_valid(out_valid), .out_ready(out_ready),
        .Q_new(Q_new), .q_max(q_max), .best_road(best_road),
        .sat_flag(sat_flag), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(longint x, longint d);
        longint q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic exp_t model(logic [63:0] d, longint r, longint qo, int a, int g);
        exp_t   e;
        longint v, mx, gq, err, s;
        int     bi;
        mx = longint'($signed(d[15:0]));
        bi = 0;
        for (int i = 1; i < 4; i++) begin
            v = longint'($signed(d[i*16 +: 16]));
            if (v > mx) begin
                mx = v;
                bi = i;
            end
        end
        gq  = mx - fdiv(mx, longint'(1) << g);
        err = (r + gq) - qo;
        s   = qo + fdiv(err, longint'(1) << a);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        e.qn = 16'(s);
        e.qm = 16'(mx);
        e.br = 2'(bi);
        return e;
    endfunction

    function automatic logic [63:0] pk(int d0, int d1, int d2, int d3);
        return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    endfunction

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            sb.delete();
            n_acc      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_qnew", Q_new, prev_qn);
                chk("hold_qmax", q_max, prev_qm);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("Q_new", Q_new, e.qn);
                    chk("q_max", q_max, e.qm);
                    chk("best_road", best_road, e.br);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(D_next, longint'(R), longint'(Q_old),
                                   int'(alpha_sh), int'(gamma_sh)));
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_qn    = Q_new;
            prev_qm    = q_max;
        end
    end

    // Present a beat and return just after the edge that accepted it.
    task automatic send(input logic [63:0] d, input logic [15:0] r, input logic [15:0] qo,
                        input logic [3:0] a, input logic [3:0] g);
        int w;
        w        = 0;
        D_next   = d;
        R        = r;
        Q_old    = qo;
        alpha_sh = a;
        gamma_sh = g;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("send_timeout", w, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", out_valid, 0);
        chk("upd_cnt_model", upd_cnt, n_acc);
    endtask

    initial begin
        int k;
        int cnt0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        D_next    = '0;
        Q_old     = '0;
        R         = '0;
        alpha_sh  = '0;
        gamma_sh  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Q_new", Q_new, 0);
        chk("rst_q_max", q_max, 0);
        chk("rst_best_road", best_road, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_upd_cnt", upd_cnt, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", in_ready, 1);

        // Basic update with a tie between roads 1 and 2
        send(pk(10, 40, 40, 5), 16'sd100, 16'sd20, 4'd2, 4'd1);
        in_valid = 1'b0;
        wait_out(k);
        chk("basic_latency", k, 4);
        chk("basic_q_max", q_max, 40);
        chk("basic_best", best_road, 1);
        chk("basic_Q_new", Q_new, 45);

        // Negative operands, floor on the shifted error
        send(pk(-100, -50, -200, -80), -16'sd10, 16'sd0, 4'd1, 4'd1);
        in_valid = 1'b0;
        wait_out(k);
        chk("neg_latency", k, 4);
        chk("neg_q_max", q_max, -50);
        chk("neg_best", best_road, 1);
        chk("neg_Q_new", Q_new, -18);

        // Saturation and sticky flag
        send(pk(32767, 32767, 32767, 32767), 16'sd32767, 16'sd32767, 4'd0, 4'd15);
        in_valid = 1'b0;
        wait_out(k);
        chk("sat_Q_new", Q_new, 32767);
        chk("sat_flag_set", sat_flag, 1);
        for (int i = 0; i < 10; i++)
            send(pk(i, 3 * i, 100 - i, -i), 16'(i * 7), 16'(i * 5), 4'd3, 4'd2);
        drain();
        chk("sat_flag_sticky", sat_flag, 1);

        // Backpressure: out_ready low for three cycles mid-stream
        cnt0 = int'(upd_cnt);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pk(i * 11, -i * 13, i * 17, 200 - i), 16'(i * 9 - 30), 16'(i * 4), 4'd1, 4'd3);
                in_valid = 1'b0;
            end
            begin
                logic signed [15:0] snap_qn, snap_qm;
                logic [1:0]         snap_br;
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    if (j == 0) begin
                        snap_qn = Q_new;
                        snap_qm = q_max;
                        snap_br = best_road;
                    end else begin
                        chk("bp_frozen_qn", Q_new, snap_qn);
                        chk("bp_frozen_qm", q_max, snap_qm);
                        chk("bp_frozen_br", best_road, snap_br);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_upd_cnt", int'(upd_cnt) - cnt0, 8);

        // Asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++)
            send(pk(i + 1, i + 2, i + 3, i + 4), 16'sd50, 16'sd10, 4'd1, 4'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_Q_new", Q_new, 0);
        chk("mid_rst_q_max", q_max, 0);
        chk("mid_rst_best", best_road, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_cnt", upd_cnt, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_valid", out_valid, 0);
        end
        send(pk(10, 40, 40, 5), 16'sd100, 16'sd20, 4'd2, 4'd1);
        in_valid = 1'b0;
        wait_out(k);
        chk("post_rst_latency", k, 4);
        chk("post_rst_Q_new", Q_new, 45);
        chk("post_rst_best", best_road, 1);
        drain();

        // Random soak
        repeat (10000) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 3) != 0);
            D_next   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) D_next[31:16] = D_next[15:0];
            if ($urandom_range(0, 7) == 0) D_next[63:48] = D_next[47:32];
            R         = 16'($urandom);
            Q_old     = 16'($urandom);
            alpha_sh  = 4'($urandom_range(0, 15));
            gamma_sh  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
